// File: rtl/mem_pwr_pkg.sv
// Shared definitions for the memory-bank power sequencer.
//   mem_pwr_state_e : sequencer FSM states
//   *_DEF           : default delay / timeout parameters
//   max3            : helper for sizing the internal counter
package mem_pwr_pkg;

  typedef enum logic [3:0] {
    ST_ON,
    ST_CLK_OFF,
    ST_ISO_ON,
    ST_SW_OFF_WAIT,
    ST_OFF,
    ST_SW_ON_WAIT,
    ST_SETTLE,
    ST_ISO_OFF,
    ST_CLK_ON
  } mem_pwr_state_e;

  localparam int unsigned ISO_DELAY_DEF   = 2;
  localparam int unsigned SETTLE_DEF      = 4;
  localparam int unsigned ACK_TIMEOUT_DEF = 255;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pwr_ack_sync.sv
// Two-flop synchronizer for the power-switch acknowledge.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset, both flops cleared to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output
module pwr_ack_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/mem_bank_pwr_ctrl.sv
// Power-switch sequencer for one memory bank.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   pwr_off_i      : level request (1 = bank off)
//   err_clr_i      : pulse clearing timeout_err_o
//   switch_ctrl_o  : switch control (1 = supply disconnected)
//   switch_ack_i   : asynchronous switch acknowledge
//   iso_o          : bank output isolation
//   mem_clk_en_o   : bank clock enable
//   mem_ready_o    : bank powered, de-isolated and clocked
//   off_o          : bank fully off
//   busy_o         : sequence in progress
//   timeout_err_o  : sticky acknowledge-timeout flag
module mem_bank_pwr_ctrl
  import mem_pwr_pkg::*;
#(
  parameter int unsigned ISO_DELAY     = ISO_DELAY_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEF,
  parameter int unsigned ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwr_off_i,
  input  logic err_clr_i,
  output logic switch_ctrl_o,
  input  logic switch_ack_i,
  output logic iso_o,
  output logic mem_clk_en_o,
  output logic mem_ready_o,
  output logic off_o,
  output logic busy_o,
  output logic timeout_err_o
);

  localparam int unsigned CNT_W = $clog2(max3(ISO_DELAY, SETTLE_CYCLES, ACK_TIMEOUT)) + 1;

  localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_DELAY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

  mem_pwr_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ack_s;
  logic             tout;
  logic             sw_d, iso_d, clk_en_d, ready_d, off_d, busy_d;

  pwr_ack_sync u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (switch_ack_i),
    .q_o    (ack_s)
  );

  always_comb begin
    state_d = state_q;
    tout    = 1'b0;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      ST_ON:          if (pwr_off_i) state_d = ST_CLK_OFF;
      ST_CLK_OFF:     state_d = ST_ISO_ON;
      ST_ISO_ON:      if (cnt_q == ISO_LAST) state_d = ST_SW_OFF_WAIT;
      ST_SW_OFF_WAIT: begin
        if (ack_s) begin
          state_d = ST_OFF;
        end else if (cnt_q == ACK_LAST) begin
          state_d = ST_OFF;
          tout    = 1'b1;
        end
      end
      ST_OFF:         if (!pwr_off_i) state_d = ST_SW_ON_WAIT;
      ST_SW_ON_WAIT: begin
        if (!ack_s) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == ACK_LAST) begin
          state_d = ST_SETTLE;
          tout    = 1'b1;
        end
      end
      ST_SETTLE:      if (cnt_q == SETTLE_LAST) state_d = ST_ISO_OFF;
      ST_ISO_OFF:     state_d = ST_CLK_ON;
      ST_CLK_ON:      state_d = ST_ON;
      default:        state_d = ST_ON;
    endcase
    // Every state entry restarts the count, so all delays are measured from entry.
    cnt_d = (state_d != state_q) ? '0 : cnt_inc;
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they change on the same edge as the state itself.
  always_comb begin
    sw_d     = 1'b0;
    iso_d    = 1'b0;
    clk_en_d = 1'b0;
    ready_d  = 1'b0;
    off_d    = 1'b0;
    busy_d   = 1'b1;
    unique case (state_d)
      ST_ON:          begin clk_en_d = 1'b1; ready_d = 1'b1; busy_d = 1'b0; end
      ST_CLK_OFF:     ;
      ST_ISO_ON:      iso_d = 1'b1;
      ST_SW_OFF_WAIT: begin sw_d = 1'b1; iso_d = 1'b1; end
      ST_OFF:         begin sw_d = 1'b1; iso_d = 1'b1; off_d = 1'b1; busy_d = 1'b0; end
      ST_SW_ON_WAIT:  iso_d = 1'b1;
      ST_SETTLE:      iso_d = 1'b1;
      ST_ISO_OFF:     ;
      ST_CLK_ON:      clk_en_d = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_ON;
      cnt_q         <= '0;
      switch_ctrl_o <= 1'b0;
      iso_o         <= 1'b0;
      mem_clk_en_o  <= 1'b1;
      mem_ready_o   <= 1'b1;
      off_o         <= 1'b0;
      busy_o        <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      switch_ctrl_o <= sw_d;
      iso_o         <= iso_d;
      mem_clk_en_o  <= clk_en_d;
      mem_ready_o   <= ready_d;
      off_o         <= off_d;
      busy_o        <= busy_d;
      timeout_err_o <= tout | (timeout_err_o & ~err_clr_i);
    end
  end

endmodule

// File: doc/mem_bank_pwr_ctrl.md
Name: mem_bank_pwr_ctrl

Overview:
Sequencer that drives one memory bank's power-switch cell, upstream of it. It takes a level power-off request from the power manager and steps the bank through a fixed order. Power-down runs clock-gate, isolate, switch off, wait for the switch acknowledge. Power-up runs the same steps in reverse, with a settle delay. It drives the switch's control input and consumes its buffered acknowledge, plus the bank's isolation and clock-enable.

Parameters:
ISO_DELAY, 2, cycles isolation is held before the switch is opened (min 1)
SETTLE_CYCLES, 4, cycles after power-up acknowledge before isolation is released (min 1)
ACK_TIMEOUT, 255, max cycles waited for acknowledge in either direction (min 1)
CNT_W, $clog2(max of the three)+1, internal counter width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
pwr_off_i  in  1  level request: 1 = bank off, 0 = bank on
err_clr_i  in  1  single-cycle pulse; clears timeout_err_o
switch_ctrl_o  out  1  to switch control input; 1 = supply disconnected, 0 = connected
switch_ack_i  in  1  buffered switch acknowledge, asynchronous; follows switch_ctrl_o
iso_o  out  1  bank output isolation enable
mem_clk_en_o  out  1  bank clock enable
mem_ready_o  out  1  bank powered, de-isolated, clocked
off_o  out  1  bank fully off
busy_o  out  1  sequence in progress
timeout_err_o  out  1  sticky acknowledge-timeout flag

Behaviour:
- Reset (rst_ni=0 at a rising edge): state ON, counters 0, sync flops 0. Outputs: switch_ctrl_o=0, iso_o=0, mem_clk_en_o=1, mem_ready_o=1, off_o=0, busy_o=0, timeout_err_o=0.
- Reset mid-sequence aborts immediately to the reset values above; no power-up sequence is replayed.
- switch_ack_i passes through a 2-flop synchronizer; the FSM uses only the synchronized value ack_s.
- All outputs are registered and decoded from state.
- FSM states:
  - ON: ready=1, clk_en=1. pwr_off_i=1 -> CLK_OFF.
  - CLK_OFF (1 cycle): ready=0, clk_en=0, busy=1. -> ISO_ON, counter loaded.
  - ISO_ON: iso=1. Stays ISO_DELAY cycles, then -> SW_OFF_WAIT.
  - SW_OFF_WAIT: switch_ctrl=1, iso=1, timeout counter running. ack_s=1 -> OFF. Counter reaching ACK_TIMEOUT -> OFF with timeout_err_o set.
  - OFF: off=1, busy=0, switch_ctrl=1, iso=1, clk_en=0. pwr_off_i=0 -> SW_ON_WAIT.
  - SW_ON_WAIT: switch_ctrl=0, iso=1, busy=1. ack_s=0 -> SETTLE. Timeout -> SETTLE with error set.
  - SETTLE: waits SETTLE_CYCLES -> ISO_OFF.
  - ISO_OFF (1 cycle): iso=0, clk_en=0. -> CLK_ON.
  - CLK_ON (1 cycle): clk_en=1. -> ON; ready=1 from the ON cycle.
- pwr_off_i is sampled only in ON and OFF. Changes during a sequence are ignored; the sequence completes, then the level is re-evaluated. A request toggled mid-off-sequence therefore yields OFF, then immediately SW_ON_WAIT.
- Invariant in every cycle: switch_ctrl_o=1 implies iso_o=1 and mem_clk_en_o=0.
- Invariant in every cycle: mem_ready_o=1 implies switch_ctrl_o=0 and iso_o=0.
- Counters saturate and never wrap. Timeout counting starts at 0 on state entry.
- timeout_err_o sets on timeout and holds until err_clr_i. If set and clear coincide, set wins.
- Latency with the acknowledge looped back at zero delay: request sampled at edge 0.
  - Power-down: CLK_OFF at edge 1, ISO_ON at edge 2, SW_OFF_WAIT at edge 4, ack_s at edge 6, OFF at edge 7.
  - Power-up: SW_ON_WAIT at edge 1, SETTLE at edge 4, ISO_OFF at edge 8, CLK_ON at edge 9, ON with mem_ready_o=1 at edge 10.

Decomposition:
- Package mem_pwr_pkg holds the FSM state enum mem_pwr_state_e and the default constants ISO_DELAY_DEF, SETTLE_DEF and ACK_TIMEOUT_DEF.
- One sub-module: pwr_ack_sync, a 2-flop synchronizer with synchronous active-low reset to 0.

Test Plan:
- Reset, then hold pwr_off_i=0 for 20 cycles -> outputs stay at reset values; busy_o never asserts.
- Acknowledge looped to switch_ctrl_o; pulse pwr_off_i=1 at edge 0 -> CLK_OFF at edge 1, iso_o=1 at edge 2, switch_ctrl_o=1 at edge 4, off_o=1 at edge 7; invariants hold throughout.
- From OFF, drop pwr_off_i -> switch_ctrl_o=0 at edge 1, iso_o=0 at edge 8, mem_ready_o=1 at edge 10.
- Acknowledge stuck at 0 with ACK_TIMEOUT=8 during power-down -> OFF entered 8 cycles into SW_OFF_WAIT with timeout_err_o=1. Flag stays set through the next power-up; err_clr_i clears it; set and clear in the same cycle leaves it 1.
- Drop pwr_off_i back to 0 during ISO_ON -> sequence still reaches OFF, then on the next cycle enters SW_ON_WAIT and returns to ON.
- Assert rst_ni=0 during SW_OFF_WAIT and during SETTLE -> the next cycle shows state ON with all reset output values.
